gray_codec_pipe: RTL and testbench
==================================

Name: gray_codec_pipe

Overview:
- Multi-lane, pipelined Gray/binary codec with a valid/ready handshake.
- The mode is selectable per transaction: encode (bin->gray) or decode (gray->bin).
- The decode prefix-XOR chain is split across STAGES register stages so that wide counters close timing.
- A per-lane adjacency checker flags decode inputs that differ from the previous decoded sample in more than one bit. This catches broken CDC pointer synchronisation.

Parameters:
- DW, 8: bits per lane; must be >= 2.
- LANES, 1: independent lanes processed in lockstep; must be >= 1.
- STAGES, 2: pipeline register stages (= latency); 1 <= STAGES <= DW.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  codec can accept a beat.
- in_mode  in  1  0 = encode bin->gray, 1 = decode gray->bin; sampled with the beat.
- in_data  in  LANES*DW  lane l occupies bits [l*DW +: DW].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_mode  out  1  in_mode carried with the beat.
- out_data  out  LANES*DW  converted data, same lane packing.
- err_clr  in  1  clears all adj_err bits.
- adj_err  out  LANES  sticky per-lane adjacency violation.

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits = 0, out_valid = 0, out_data = 0, out_mode = 0, adj_err = 0, per-lane have_prev = 0, prev = 0. in_ready = 1 once reset is released.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - out_valid/out_data/out_mode are held stable while out_valid && !out_ready.
  - in_valid must not depend on in_ready.
- Elastic pipeline:
  - stage_ready[k] = !stage_valid[k] || stage_ready[k+1]; stage_ready[STAGES] = out_ready; in_ready = stage_ready[0].
  - Full throughput is 1 beat/cycle. Bubbles collapse when downstream stalls.
  - Latency is exactly STAGES cycles from an accepted input to out_valid with out_ready held high.
- Encode: gray = b ^ (b >> 1), computed entirely in stage 0; later stages pass through.
- Decode:
  - Bits are partitioned MSB-first into STAGES slices of ceil(DW/STAGES) bits; the last slice may be short or empty.
  - Stage k resolves its slice as bin[i] = bin[i+1] ^ gray[i], using the resolved bin bit carried from slice k-1. For slice 0 the carry is 0, so bin[DW-1] = gray[DW-1].
  - Unresolved gray bits ride along in the stage register.
- Result must equal the full combinational conversion for every DW/STAGES pairing, including STAGES = DW and STAGES = 1.
- Lanes are fully independent; no carries cross lanes.
- Adjacency check, per lane, evaluated only on accepted decode beats at stage-0 entry:
  - If have_prev and popcount(gray ^ prev) > 1, then adj_err[l] <= 1.
  - prev <= gray; have_prev <= 1.
  - Zero-bit change (repeat value) is legal.
  - The wrap from 100..0 to 000..0 is a single-bit change and is therefore legal.
  - Encode beats neither check nor update prev.
- err_clr clears adj_err the next cycle. If err_clr coincides with a new violation, the set wins. err_clr does not clear have_prev/prev.
- Reset mid-operation: all in-flight beats are discarded and no partial output is produced.

Decomposition:
- Package gray_pkg: typedef enum logic {GRAY_ENC = 0, GRAY_DEC = 1} gray_mode_e; function slice_w(DW, STAGES) = ceil div; function popcount.
- Sub-module gray_adj_check: one per lane, generated LANES times. It holds prev, have_prev and adj_err.
- The pipeline lives in the top.

Test Plan:
1. DW=8, STAGES=2, LANES=1, out_ready=1: decode gray 0x0C -> out_data 0x08 after exactly 2 cycles; encode bin 0x08 -> 0x0C; out_mode matches the input.
2. Exhaustive decode of 0..255 back-to-back with DW=8, all of STAGES=1,3,8 -> out_data equals the reference conversion every cycle; no bubbles at 1 beat/cycle.
3. Random out_ready backpressure with 1000 mixed-mode beats -> no drop/duplicate; order preserved; output held stable while stalled; in_ready low only when the pipeline is full.
4. LANES=2, decode sequence lane0 gray 0x00, 0x01, 0x03; lane1 gray 0x00, 0x03 -> adj_err = 2'b10; then err_clr -> 2'b00; then lane1 gray 0x02 (one bit from 0x03) -> stays 2'b00.
5. err_clr asserted in the same cycle a lane0 violation (0x00 -> 0x0F) is accepted -> adj_err[0] = 1; decode 0x80 -> 0x00 wrap -> no error.
6. Assert rst with 2 beats in flight -> out_valid = 0 immediately; adj_err = 0; the first decode after reset never flags, since have_prev = 0.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared types and helpers for the Gray/binary codec pipeline.
// Revision : 1.0
// ============================================================================
package gray_pkg;

    typedef enum logic {
        GRAY_ENC = 1'b0,
        GRAY_DEC = 1'b1
    } gray_mode_e;

    // Widest lane the popcount helper handles.
    localparam int c_POP_W = 256;

    function automatic int slice_w(input int dw, input int stages);
        return (dw + stages - 1) / stages;
    endfunction

    function automatic int unsigned popcount(input logic [c_POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_POP_W; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_adj_check.sv
`default_nettype none
// ============================================================================
// Module   : gray_adj_check
// Purpose  : Sticky flag for decode samples that move more than one bit.
// Revision : 1.0
// ============================================================================
module gray_adj_check
    import gray_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          chk_en,
    input  logic          err_clr,
    input  logic [DW-1:0] gray,
    output logic          adj_err
);

    logic [DW-1:0] r_prev;
    logic          r_have_prev;
    logic          r_err;
    logic          w_viol;

    assign w_viol = chk_en && r_have_prev &&
                    (popcount(c_POP_W'(gray ^ r_prev)) > 32'd1);

    // A new violation outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_viol) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (chk_en) begin
                r_prev      <= gray;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign adj_err = r_err;

endmodule
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gray_codec_pipe
// Purpose  : Multi-lane elastic Gray encode/decode pipeline with adjacency check.
// Revision : 1.0
// ============================================================================
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int DW     = 8,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [LANES*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [LANES*DW-1:0] out_data,
    input  logic                err_clr,
    output logic [LANES-1:0]    adj_err
);

    localparam int c_SW = slice_w(DW, STAGES);
    localparam int c_W  = LANES * DW;

    logic [STAGES-1:0] r_vld;
    gray_mode_e        r_mode     [STAGES];
    logic [c_W-1:0]    r_data     [STAGES];

    logic [STAGES-1:0] w_srdy;
    logic [STAGES-1:0] w_up_vld;
    gray_mode_e        w_src_mode [STAGES];
    logic [c_W-1:0]    w_src_data [STAGES];
    logic [c_W-1:0]    w_nxt_data [STAGES];
    logic              w_chk_en;

    // Resolve slice k (MSB-first); bits above are already binary, bits below still Gray.
    function automatic logic [DW-1:0] dec_slice(input logic [DW-1:0] v, input int k);
        logic [DW-1:0] t;
        int            hi;
        int            lo;
        t  = v;
        hi = DW - 1 - k * c_SW;
        lo = DW - (k + 1) * c_SW;
        for (int i = DW - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) t[i] = t[i+1] ^ t[i];
        end
        return t;
    endfunction

    always_comb begin
        logic rdy;
        w_srdy = '0;
        rdy    = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy       = !r_vld[k] || rdy;
            w_srdy[k] = rdy;
        end
    end

    assign w_up_vld[0]   = in_valid;
    assign w_src_mode[0] = gray_mode_e'(in_mode);
    assign w_src_data[0] = in_data;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign w_up_vld[k]   = r_vld[k-1];
        assign w_src_mode[k] = r_mode[k-1];
        assign w_src_data[k] = r_data[k-1];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_data[k] = w_src_data[k];
            for (int l = 0; l < LANES; l++) begin
                if (w_src_mode[k] == GRAY_DEC) begin
                    w_nxt_data[k][l*DW +: DW] = dec_slice(w_src_data[k][l*DW +: DW], k);
                end else if (k == 0) begin
                    w_nxt_data[k][l*DW +: DW] = w_src_data[k][l*DW +: DW] ^
                                                (w_src_data[k][l*DW +: DW] >> 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_mode[k] <= GRAY_ENC;
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_srdy[k]) begin
                    r_vld[k] <= w_up_vld[k];
                    if (w_up_vld[k]) begin
                        r_mode[k] <= w_src_mode[k];
                        r_data[k] <= w_nxt_data[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_srdy[0];
    assign out_valid = r_vld[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];
    assign out_data  = r_data[STAGES-1];

    assign w_chk_en = in_valid && w_srdy[0] && (in_mode == GRAY_DEC);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gray_adj_check #(
            .DW(DW)
        ) u_adj (
            .clk     (clk),
            .rst     (rst),
            .chk_en  (w_chk_en),
            .err_clr (err_clr),
            .gray    (in_data[l*DW +: DW]),
            .adj_err (adj_err[l])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_codec_pipe
// Purpose  : Self-checking bench for gray_codec_pipe (vectors, random, corners).
// Revision : 1.0
// ============================================================================
module tb_gray_codec_pipe;

    localparam int c_ST_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_mode, out_ready, err_clr;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_mode;
    logic [15:0] out_data;
    logic [1:0]  adj_err;

    logic            x_valid;
    logic [7:0]      x_data;
    logic [2:0]      x_in_ready, x_out_valid, x_out_mode, x_adj;
    logic [2:0][7:0] x_out_data;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct { logic mode; logic [15:0] din; logic [15:0] exp; } vec_t;
    typedef struct { logic m; logic [15:0] d; } exp_t;
    vec_t tbl [6];
    exp_t q [$];

    gray_codec_pipe #(.DW(8), .LANES(2), .STAGES(c_ST_A)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .err_clr(err_clr), .adj_err(adj_err)
    );

    for (genvar g = 0; g < 3; g++) begin : g_x
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : 8;
        gray_codec_pipe #(.DW(8), .LANES(1), .STAGES(ST)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(x_valid), .in_ready(x_in_ready[g]), .in_mode(1'b1), .in_data(x_data),
            .out_valid(x_out_valid[g]), .out_ready(1'b1), .out_mode(x_out_mode[g]),
            .out_data(x_out_data[g]), .err_clr(1'b0), .adj_err(x_adj[g])
        );
    end

    function automatic int st_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 8;
    endfunction

    // Reference: binary is the XOR of all right-shifts of the Gray word.
    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [15:0] ref_lanes(input logic m, input logic [15:0] d);
        logic [15:0] r;
        logic [7:0]  v;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            v = d[l*8 +: 8];
            r[l*8 +: 8] = m ? ref_g2b(v) : (v ^ (v >> 1));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic m, input logic [15:0] d, input logic clr);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        err_clr  = clr;
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_mode = 0; in_data = 0; out_ready = 1; err_clr = 0;
        x_valid = 0; x_data = 0;
        tbl[0] = '{1'b1, 16'h000C, 16'h0008};
        tbl[1] = '{1'b0, 16'h0008, 16'h000C};
        tbl[2] = '{1'b0, 16'hFF01, 16'h8001};
        tbl[3] = '{1'b1, 16'h80FF, 16'hFFAA};
        tbl[4] = '{1'b0, 16'h55AA, 16'h7FFF};
        tbl[5] = '{1'b1, 16'h015A, 16'h016C};

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_adj_err", adj_err, 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors with exact two-cycle latency.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_mode = tbl[i].mode; in_data = tbl[i].din;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_early", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].exp);
            chk($sformatf("vec%0d_mode", i), out_mode, tbl[i].mode);
            @(negedge clk);
        end

        // Back-to-back exhaustive decode on STAGES = 1, 3, 8.
        for (int t = 0; t < 266; t++) begin
            for (int g = 0; g < 3; g++) begin
                int b;
                b = t - st_of(g);
                chk($sformatf("exh%0d_valid_t%0d", g, t), x_out_valid[g], (b >= 0 && b < 256));
                if (b >= 0 && b < 256) begin
                    chk($sformatf("exh%0d_data_%0d", g, b), x_out_data[g], ref_g2b(8'(b)));
                    chk($sformatf("exh%0d_mode_%0d", g, b), x_out_mode[g], 1);
                end
                if (t < 256) chk($sformatf("exh%0d_ready_t%0d", g, t), x_in_ready[g], 1);
            end
            x_valid = (t < 256);
            x_data  = 8'(t);
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) chk($sformatf("exh%0d_adj", g), x_adj[g], 1);

        // Random mixed-mode traffic under random backpressure.
        begin : rnd
            int          acc;
            int          cyc;
            logic        stalled;
            logic [15:0] hd;
            logic        hm;
            exp_t        e;
            acc = 0; cyc = 0; stalled = 0; hd = 0; hm = 0;
            while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
                if (stalled) begin
                    chk("rnd_hold_valid", out_valid, 1);
                    chk("rnd_hold_data", out_data, hd);
                    chk("rnd_hold_mode", out_mode, hm);
                end
                out_ready = ($urandom_range(99) < 60);
                in_valid  = (acc < 1000) && ($urandom_range(99) < 75);
                in_mode   = 1'($urandom);
                in_data   = 16'($urandom);
                #1;
                chk("rnd_in_ready", in_ready, !(q.size() == c_ST_A && !out_ready));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("rnd_extra_beat", 32'(q.size()), 1);
                    end else begin
                        e = q.pop_front();
                        chk("rnd_data", out_data, e.d);
                        chk("rnd_mode", out_mode, e.m);
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back('{in_mode, ref_lanes(in_mode, in_data)});
                    acc++;
                end
                stalled = out_valid && !out_ready;
                hd = out_data;
                hm = out_mode;
                cyc++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk("rnd_accepted", acc, 1000);
            chk("rnd_drained", q.size(), 0);
        end

        // Reset with two beats in flight.
        do_reset();
        out_ready = 1'b0;
        send(1'b1, 16'h0000, 1'b0);
        send(1'b1, 16'h00FF, 1'b0);
        chk("inflight_valid", out_valid, 1);
        chk("inflight_ready", in_ready, 0);
        chk("inflight_err", adj_err, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_err", adj_err, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", i), out_valid, 0);
        end
        send(1'b1, 16'h0F0F, 1'b0);
        chk("first_dec_noflag", adj_err, 0);
        @(negedge clk);
        chk("first_dec_valid", out_valid, 1);
        chk("first_dec_data", out_data, 16'h0A0A);

        // Per-lane adjacency and clear.
        do_reset();
        send(1'b1, 16'h0000, 1'b0);
        send(1'b1, 16'h0301, 1'b0);
        send(1'b1, 16'h0303, 1'b0);
        chk("adj_lane1_flag", adj_err, 2'b10);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("adj_clear", adj_err, 2'b00);
        send(1'b1, 16'h0203, 1'b0);
        chk("adj_one_bit", adj_err, 2'b00);

        // Set beats clear; wrap 0x80 -> 0x00 is legal.
        send(1'b1, 16'h0202, 1'b0);
        send(1'b1, 16'h0200, 1'b0);
        chk("adj_walk", adj_err, 2'b00);
        send(1'b1, 16'h020F, 1'b1);
        chk("adj_set_wins", adj_err, 2'b01);
        send(1'b1, 16'h0280, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("adj_clear2", adj_err, 2'b00);
        send(1'b1, 16'h0200, 1'b0);
        chk("adj_wrap", adj_err, 2'b00);
        send(1'b0, 16'hF0F0, 1'b0);
        chk("adj_enc_ignored", adj_err, 2'b00);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
